// File: rtl/fifo_sc.sv
// Single-clock FIFO with a registered read port, for rate smoothing between a
// producer and a consumer in one clock domain. Its interface matches the stack buffer's.
module fifo_sc #(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 3,
    parameter int ALMOST_FULL_VALUE  = 6,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AWIDTH-1:0] usedw_o
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0]   CNT_FULL = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH:0]   AF_LVL   = ALMOST_FULL_VALUE[AWIDTH:0];
    localparam logic [AWIDTH:0]   AE_LVL   = ALMOST_EMPTY_VALUE[AWIDTH:0];

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   count_next;
    logic              wr_acc;
    logic              rd_acc;

    // The registered flags gate acceptance, so reading an empty FIFO or writing a full one is a no-op.
    always_comb begin
        wr_acc     = wrreq_i & ~full_o;
        rd_acc     = rdreq_i & ~empty_o;
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Flags come from the next-state count, so they are valid one cycle after the causing edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            q_o            <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            usedw_o        <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                q_o    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count          <= count_next;
            empty_o        <= (count_next == '0);
            full_o         <= (count_next == CNT_FULL);
            almost_full_o  <= (count_next >= AF_LVL);
            almost_empty_o <= (count_next < AE_LVL);
            usedw_o        <= count_next[AWIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fifo_sc.sv
// Directed self-checking bench for fifo_sc: ordering, full/empty boundaries,
// simultaneous requests, pointer wrap and asynchronous reset.
module tb_fifo_sc;

    logic       clk_i;
    logic       rst_n_i;
    logic [7:0] data_i;
    logic       wrreq_i;
    logic       rdreq_i;
    logic [7:0] q_o;
    logic       empty_o;
    logic       full_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic [2:0] usedw_o;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_sc #(
        .DWIDTH(8),
        .AWIDTH(3),
        .ALMOST_FULL_VALUE(6),
        .ALMOST_EMPTY_VALUE(2)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .data_i(data_i),
        .wrreq_i(wrreq_i),
        .rdreq_i(rdreq_i),
        .q_o(q_o),
        .empty_o(empty_o),
        .full_o(full_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o),
        .usedw_o(usedw_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flag and usedw expectations for a given stored-word count.
    task automatic chk_count(input string tag, input int c);
        chk({tag, ".empty"}, 32'(empty_o), 32'(c == 0));
        chk({tag, ".full"}, 32'(full_o), 32'(c == 8));
        chk({tag, ".afull"}, 32'(almost_full_o), 32'(c >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty_o), 32'(c < 2));
        chk({tag, ".usedw"}, 32'(usedw_o), 32'(c % 8));
    endtask

    initial begin
        rst_n_i = 1'b0;
        data_i  = 8'h00;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;

        // Reset then idle.
        tick();
        tick();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        tick();
        chk("reset.q", 32'(q_o), 32'h00);
        chk_count("reset", 0);

        // Sequential fill and drain of 8'h11..8'h18.
        for (int i = 0; i < 8; i++) begin
            data_i  = 8'h11 + 8'(i);
            wrreq_i = 1'b1;
            tick();
            chk_count($sformatf("fill%0d", i), i + 1);
        end
        wrreq_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdreq_i = 1'b1;
            tick();
            chk($sformatf("drain%0d.q", i), 32'(q_o), 32'(8'h11 + 8'(i)));
            chk_count($sformatf("drain%0d", i), 7 - i);
        end
        rdreq_i = 1'b0;

        // Writes to a full FIFO are dropped.
        for (int i = 0; i < 8; i++) begin
            data_i  = 8'h20 + 8'(i);
            wrreq_i = 1'b1;
            tick();
        end
        data_i = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_count($sformatf("ovf%0d", i), 8);
        end
        wrreq_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdreq_i = 1'b1;
            tick();
            chk($sformatf("ovfrd%0d.q", i), 32'(q_o), 32'(8'h20 + 8'(i)));
        end
        chk_count("ovfrd.end", 0);

        // A read of an empty FIFO changes nothing.
        tick();
        rdreq_i = 1'b0;
        tick();
        chk("udf.q", 32'(q_o), 32'h27);
        chk_count("udf", 0);

        // Steady-state streaming with 4 words held; the pointers wrap three times.
        for (int i = 0; i < 4; i++) begin
            data_i  = 8'h30 + 8'(i);
            wrreq_i = 1'b1;
            tick();
        end
        rdreq_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_i = 8'h34 + 8'(i);
            tick();
            chk($sformatf("stream%0d.q", i), 32'(q_o), 32'(8'h30 + 8'(i)));
            chk($sformatf("stream%0d.usedw", i), 32'(usedw_o), 32'd4);
        end
        wrreq_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("streamdrain%0d.q", i), 32'(q_o), 32'(8'h44 + 8'(i)));
        end
        rdreq_i = 1'b0;
        chk_count("streamdrain.end", 0);

        // Simultaneous requests while empty: write only, no fall-through.
        data_i  = 8'h5C;
        wrreq_i = 1'b1;
        rdreq_i = 1'b1;
        tick();
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        chk("bothempty.q", 32'(q_o), 32'h47);
        chk_count("bothempty", 1);
        rdreq_i = 1'b1;
        tick();
        rdreq_i = 1'b0;
        chk("bothempty.rd.q", 32'(q_o), 32'h5C);
        chk_count("bothempty.rd", 0);

        // Simultaneous requests while full: read only, the write is dropped.
        for (int i = 0; i < 8; i++) begin
            data_i  = 8'h60 + 8'(i);
            wrreq_i = 1'b1;
            tick();
        end
        data_i  = 8'hEE;
        rdreq_i = 1'b1;
        tick();
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        chk("bothfull.q", 32'(q_o), 32'h60);
        chk_count("bothfull", 7);
        rdreq_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("bothfull.rd%0d.q", i), 32'(q_o), 32'(8'h61 + 8'(i)));
        end
        rdreq_i = 1'b0;
        chk_count("bothfull.end", 0);

        // Asynchronous reset in mid-cycle with 5 words held.
        for (int i = 0; i < 5; i++) begin
            data_i  = 8'h70 + 8'(i);
            wrreq_i = 1'b1;
            tick();
        end
        wrreq_i = 1'b0;
        rdreq_i = 1'b1;
        tick();
        rdreq_i = 1'b0;
        chk("prerst.q", 32'(q_o), 32'h70);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("arst.q", 32'(q_o), 32'h00);
        chk_count("arst", 0);
        tick();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        chk_count("postrst", 0);
        data_i  = 8'h3C;
        wrreq_i = 1'b1;
        tick();
        wrreq_i = 1'b0;
        chk_count("postrst.wr", 1);
        rdreq_i = 1'b1;
        tick();
        rdreq_i = 1'b0;
        chk("postrst.rd.q", 32'(q_o), 32'h3C);
        chk_count("postrst.rd", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sc.md
Name: fifo_sc

Overview:
Single-clock, first-in/first-out buffer. It is the queue-ordered counterpart to the team's stack buffer and uses the same data, request, flag and usedw interface style, so the two are interchangeable at a client. Its placement is between a producer and a consumer in the same clock domain, for rate smoothing. Reads are registered: data appears on q_o one clock after an accepted read.

Parameters:
DWIDTH, 8, data word width in bits
AWIDTH, 3, address width; depth = 2**AWIDTH words
ALMOST_FULL_VALUE, 6, almost_full_o asserts when the count is >= this value
ALMOST_EMPTY_VALUE, 2, almost_empty_o asserts when the count is < this value

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_n_i  in  1  reset, asynchronous, active-low; asserts immediately, releases synchronously to clk_i
data_i  in  DWIDTH  write data
wrreq_i  in  1  write request
rdreq_i  in  1  read request
q_o  out  DWIDTH  read data (registered)
empty_o  out  1  FIFO holds 0 words
full_o  out  1  FIFO holds 2**AWIDTH words
almost_full_o  out  1  count >= ALMOST_FULL_VALUE
almost_empty_o  out  1  count < ALMOST_EMPTY_VALUE
usedw_o  out  AWIDTH  number of stored words modulo 2**AWIDTH; reads 0 when full

Behaviour:
- Reset (rst_n_i = 0, any time, including mid-transfer):
  - q_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0, usedw_o = 0.
  - Both pointers return to 0.
  - Memory contents are don't-care and are not cleared.
- Internal state:
  - wr_ptr and rd_ptr, each AWIDTH bits; they wrap naturally from 2**AWIDTH-1 to 0.
  - count, AWIDTH+1 bits, range 0..2**AWIDTH.
- Acceptance, per cycle:
  - wr_acc = wrreq_i & !full_o
  - rd_acc = rdreq_i & !empty_o
  - Requests that are not accepted are ignored silently: no state change and no error flag.
- wr_acc: mem[wr_ptr] <= data_i; wr_ptr increments.
- rd_acc: q_o <= mem[rd_ptr]; rd_ptr increments.
  - q_o is valid in the cycle after the read edge.
  - q_o holds its value until the next rd_acc.
- count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- Simultaneous wrreq_i and rdreq_i:
  - Not empty and not full: both accepted, count unchanged, q_o gets the oldest word.
  - Empty: write only. Read-during-empty never returns the word being written (no fall-through).
  - Full: read only. The write is dropped, and full_o falls next cycle.
- Same-address read/write in one cycle cannot occur, because it requires the FIFO to be empty or full, and those cases are handled above.
- All flags and usedw_o are registered and derived from the next-state count, so they are valid the cycle after the causing edge:
  - empty_o = (count == 0)
  - full_o = (count == 2**AWIDTH)
  - usedw_o = count[AWIDTH-1:0]
  - almost_full_o = (count >= ALMOST_FULL_VALUE)
  - almost_empty_o = (count < ALMOST_EMPTY_VALUE)
- Ordering: words are read in exactly the order written, across any number of pointer wraps.
- Latency:
  - Write to empty_o falling: 1 clock.
  - Write to first readable data: rdreq_i may be asserted in the cycle after the write; q_o is valid one clock later.
- Memory is inferable as a simple dual-port RAM: one synchronous write port, one synchronous registered read port.

Test Plan:
1. Reset, then idle with no requests -> empty_o = 1, full_o = 0, usedw_o = 0, q_o = 0, almost_empty_o = 1.
2. Write 8'h11..8'h18 on consecutive cycles, then read 8 times -> full_o = 1 and usedw_o = 0 after the 8th write; q_o returns 8'h11..8'h18 in order; empty_o = 1 after the last read; almost_full_o rises after the 6th write.
3. Fill to full, then hold wrreq_i=1 with data 8'hAA for 3 cycles -> no change; subsequent reads never return 8'hAA. With the FIFO empty, pulse rdreq_i -> q_o, flags and usedw_o are all unchanged.
4. Hold 4 words, then assert wrreq_i=1 and rdreq_i=1 for 20 cycles with an incrementing data pattern -> usedw_o stays 4; q_o is the data written 4 accepted writes earlier; pointers wrap at least twice with no corruption.
5. Simultaneous requests at the boundaries:
   - Empty with both asserted (data 8'h5C) -> next cycle usedw_o = 1, q_o unchanged.
   - Full with both asserted -> oldest word is read, usedw_o = 7, full_o = 0, written data is dropped.
6. Assert rst_n_i low asynchronously, mid-clock, while 5 words are held -> all outputs reach their reset values before the next clock edge. After release, write 8'h3C and read it -> q_o = 8'h3C, with no stale data from before the reset.
